// File: rtl/uart_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
package uart_pkg;

   // Transmit FSM states; encoding is fixed so the state is readable on a probe.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_e;

   // Bit positions inside the STATUS word.
   localparam int STAT_TX_ACTIVE = 0;
   localparam int STAT_HOLD_FULL = 1;
   localparam int STAT_OVERRUN   = 2;

   // Default register map and bit timing (50 MHz / 115200).
   localparam logic [31:0] DEF_DATA_ADDR   = 32'h1001_0024;
   localparam logic [31:0] DEF_STATUS_ADDR = 32'h1001_0028;
   localparam int          DEF_BAUD_DIV    = 434;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: emits a one-cycle tick every BAUD_DIV enabled cycles.
module uart_baud_tick #(
   parameter int BAUD_DIV = 434
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic enable_i,
   output logic tick_o
);

   localparam int            CW   = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign tick_o = enable_i && (cnt_q == LAST);

   // Count while enabled; wrap on tick; hold at zero while idle so every frame starts aligned.
   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (!enable_i || tick_o) cnt_d = '0;
   end

   // Counter register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter with a one-entry holding register.
module uart_tx_mmio
   import uart_pkg::*;
#(
   parameter int          BAUD_DIV    = DEF_BAUD_DIV,
   parameter logic [31:0] DATA_ADDR   = DEF_DATA_ADDR,
   parameter logic [31:0] STATUS_ADDR = DEF_STATUS_ADDR
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Address,
   input  logic [31:0] WriteData,
   input  logic        MemWrite,
   input  logic        MemRead,
   output logic [31:0] ReadData,
   output logic        TxOut,
   output logic        Busy
);

   tx_state_e   state_q, state_d;
   logic [7:0]  hold_q, hold_d;
   logic        full_q, full_d;
   logic        ovr_q, ovr_d;
   logic [7:0]  shift_q, shift_d;
   logic [2:0]  idx_q, idx_d;
   logic        tx_q, tx_d;
   logic        load;
   logic        tick;
   logic        tx_active;
   logic        wr_fire;
   logic        rd_stat;
   logic        wdata_unused;

   assign tx_active    = (state_q != IDLE);
   assign wr_fire      = MemWrite && (Address == DATA_ADDR);
   assign rd_stat      = MemRead && (Address == STATUS_ADDR);
   assign wdata_unused = ^WriteData[31:8];

   uart_baud_tick #(.BAUD_DIV(BAUD_DIV)) u_tick (
      .clk_i   (clk),
      .rst_ni  (reset),
      .enable_i(tx_active),
      .tick_o  (tick)
   );

   // Next-state logic for the frame FSM, holding register and sticky overrun.
   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      full_d  = full_q;
      ovr_d   = ovr_q;
      shift_d = shift_q;
      idx_d   = idx_q;
      load    = 1'b0;

      case (state_q)
         IDLE:  if (full_q) begin
                   load    = 1'b1;
                   state_d = START;
                end
         START: if (tick) begin
                   state_d = DATA;
                   idx_d   = 3'd0;
                end
         DATA:  if (tick) begin
                   shift_d = shift_q >> 1;
                   if (idx_q == 3'd7) state_d = STOP;
                   else               idx_d   = idx_q + 3'd1;
                end
         STOP:  if (tick) begin
                   if (full_q) begin
                      load    = 1'b1;
                      state_d = START;
                   end else begin
                      state_d = IDLE;
                   end
                end
         default: state_d = IDLE;
      endcase

      // A load frees the holding slot in the same edge, so a coincident write still fits.
      if (load) begin
         shift_d = hold_q;
         full_d  = 1'b0;
      end

      if (rd_stat) ovr_d = 1'b0;

      if (wr_fire) begin
         if (!full_q || load) begin
            hold_d = WriteData[7:0];
            full_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end

      // Line level follows the next state so TxOut changes together with the state.
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
         default: tx_d = 1'b1;
      endcase
   end

   // State and datapath registers; reset abandons any frame and drives the line idle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         hold_q  <= '0;
         full_q  <= 1'b0;
         ovr_q   <= 1'b0;
         shift_q <= '0;
         idx_q   <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         full_q  <= full_d;
         ovr_q   <= ovr_d;
         shift_q <= shift_d;
         idx_q   <= idx_d;
         tx_q    <= tx_d;
      end
   end

   // Status read mux; zero unless the status register is being loaded.
   always_comb begin
      ReadData = '0;
      if (rd_stat) begin
         ReadData[STAT_TX_ACTIVE] = tx_active;
         ReadData[STAT_HOLD_FULL] = full_q;
         ReadData[STAT_OVERRUN]   = ovr_q;
      end
   end

   assign TxOut = tx_q;
   assign Busy  = tx_active | full_q;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio with BAUD_DIV=4: decode table plus frame sequences.
module tb_uart_tx_mmio;

   localparam int          BD    = 4;
   localparam logic [31:0] DADDR = 32'h1001_0024;
   localparam logic [31:0] SADDR = 32'h1001_0028;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] Address;
   logic [31:0] WriteData;
   logic        MemWrite;
   logic        MemRead;
   logic [31:0] ReadData;
   logic        TxOut;
   logic        Busy;

   int nerr = 0;
   int nchk = 0;
   logic trace[$];

   uart_tx_mmio #(.BAUD_DIV(BD), .DATA_ADDR(DADDR), .STATUS_ADDR(SADDR)) dut (
      .clk      (clk),
      .reset    (reset),
      .Address  (Address),
      .WriteData(WriteData),
      .MemWrite (MemWrite),
      .MemRead  (MemRead),
      .ReadData (ReadData),
      .TxOut    (TxOut),
      .Busy     (Busy)
   );

   always #5 clk = ~clk;

   // Line trace: element k is TxOut just after the (k+1)-th rising edge.
   always @(posedge clk) begin
      #1;
      trace.push_back(TxOut);
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      string       name;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        we;
      logic        re;
      logic [31:0] exp_rd;
      logic        exp_tx;
      logic        exp_busy;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      Address = a; WriteData = d; MemWrite = 1'b1;
      tick();
      MemWrite = 1'b0; Address = '0; WriteData = '0;
   endtask

   task automatic read_status(input string nm, input logic [31:0] exp);
      Address = SADDR; MemRead = 1'b1;
      #1;
      chk(nm, ReadData, exp);
      tick();
      MemRead = 1'b0; Address = '0;
   endtask

   task automatic wait_size(input int n);
      int guard = 0;
      while (trace.size() < n && guard < 2000) begin
         tick();
         guard++;
      end
      if (trace.size() < n) begin
         nchk++; nerr++;
         $display("FAIL timeout: trace %0d of %0d", trace.size(), n);
      end
   endtask

   // Compare one 8N1 frame starting at trace index st, one check per bit period.
   task automatic check_frame(input string nm, input int st, input logic [7:0] b);
      logic       e;
      logic [3:0] got;
      wait_size(st + 10*BD);
      if (trace.size() >= st + 10*BD) begin
         for (int j = 0; j < 10; j++) begin
            e = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : b[j-1];
            for (int k = 0; k < BD; k++) got[k] = trace[st + j*BD + k];
            chk($sformatf("%s bit%0d", nm, j), 32'(got), 32'({4{e}}));
         end
      end
   endtask

   task automatic check_idle(input string nm, input int st);
      logic [3:0] got;
      wait_size(st + 4);
      if (trace.size() >= st + 4) begin
         for (int k = 0; k < 4; k++) got[k] = trace[st + k];
         chk(nm, 32'(got), 32'hF);
      end
   endtask

   initial begin
      vec_t vecs[6];
      int   w;

      reset = 1'b0; Address = '0; WriteData = '0; MemWrite = 1'b0; MemRead = 1'b0;
      repeat (3) tick();
      chk("reset TxOut", 32'(TxOut), 32'h1);
      chk("reset Busy", 32'(Busy), 32'h0);
      Address = SADDR; MemRead = 1'b1; #1;
      chk("reset STATUS", ReadData, 32'h0);
      MemRead = 1'b0; Address = '0;
      reset = 1'b1;
      tick();

      // Address decode: nothing but DATA writes or STATUS reads has an effect.
      vecs[0] = '{"rd status idle", SADDR,         32'h0,  1'b0, 1'b1, 32'h0, 1'b1, 1'b0};
      vecs[1] = '{"wr data+4",      DADDR + 32'd4, 32'hA5, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0};
      vecs[2] = '{"wr 10010000",    32'h1001_0000, 32'h5A, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0};
      vecs[3] = '{"rd data addr",   DADDR,         32'h0,  1'b0, 1'b1, 32'h0, 1'b1, 1'b0};
      vecs[4] = '{"status no rd",   SADDR,         32'h0,  1'b0, 1'b0, 32'h0, 1'b1, 1'b0};
      vecs[5] = '{"wr status addr", SADDR,         32'hFF, 1'b1, 1'b1, 32'h0, 1'b1, 1'b0};
      for (int i = 0; i < 6; i++) begin
         Address = vecs[i].addr; WriteData = vecs[i].wdata;
         MemWrite = vecs[i].we; MemRead = vecs[i].re;
         #1;
         chk({vecs[i].name, " rd"}, ReadData, vecs[i].exp_rd);
         tick();
         MemWrite = 1'b0; MemRead = 1'b0; Address = '0; WriteData = '0;
         tick(); tick();
         chk({vecs[i].name, " tx"}, 32'(TxOut), 32'(vecs[i].exp_tx));
         chk({vecs[i].name, " busy"}, 32'(Busy), 32'(vecs[i].exp_busy));
      end

      // Single byte: line stays high after the write edge, falls one edge later.
      bus_write(DADDR, 32'h0000_00A5);
      w = trace.size();
      chk("single high at write", 32'(trace[w-1]), 32'h1);
      read_status("single held", 32'h2);
      read_status("single active", 32'h1);
      check_frame("single", w, 8'hA5);
      check_idle("single idle after", w + 40);
      read_status("single done", 32'h0);

      // Back-to-back: second byte written during START follows the STOP bit directly.
      bus_write(DADDR, 32'h55);
      w = trace.size();
      tick();
      bus_write(DADDR, 32'h0F);
      check_frame("b2b f1", w, 8'h55);
      check_frame("b2b f2", w + 40, 8'h0F);
      check_idle("b2b idle", w + 80);
      read_status("b2b done", 32'h0);

      // Overrun: third consecutive write is dropped and flagged until read.
      bus_write(DADDR, 32'h55);
      w = trace.size();
      bus_write(DADDR, 32'h0F);
      bus_write(DADDR, 32'hC3);
      read_status("ovr first read", 32'h7);
      read_status("ovr cleared", 32'h3);
      check_frame("ovr f1", w, 8'h55);
      check_frame("ovr f2", w + 40, 8'h0F);
      check_idle("ovr no third", w + 80);
      read_status("ovr done", 32'h0);

      // Write lands on the STOP tick that reloads from a full holding register.
      bus_write(DADDR, 32'h3C);
      w = trace.size();
      tick();
      bus_write(DADDR, 32'h96);
      read_status("same held", 32'h3);
      wait_size(w + 40);
      bus_write(DADDR, 32'h81);
      read_status("same no ovr", 32'h3);
      check_frame("same f1", w, 8'h3C);
      check_frame("same f2", w + 40, 8'h96);
      check_frame("same f3", w + 80, 8'h81);
      check_idle("same idle", w + 120);
      read_status("same done", 32'h0);

      // Reset mid-frame while a zero data bit is on the line.
      bus_write(DADDR, 32'hA5);
      w = trace.size();
      wait_size(w + 9);
      chk("mid data low", 32'(TxOut), 32'h0);
      #3 reset = 1'b0;
      #1;
      chk("mid reset TxOut", 32'(TxOut), 32'h1);
      chk("mid reset Busy", 32'(Busy), 32'h0);
      tick(); tick();
      reset = 1'b1;
      tick();
      read_status("mid status after", 32'h0);
      w = trace.size();
      check_idle("mid idle after", w);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
